// File: rtl/exec_trace_if.sv
// Bundles every non-clock signal of the execution trace monitor.
// master: the side driving core events, configuration and pops (core + host).
// slave:  the trace monitor itself.
interface exec_trace_if #(
    parameter int PC_W    = 11,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 16,
    parameter int N_BKPT  = 2,
    parameter int TMO_W   = 16
);
    localparam int ENTRY_W = 2 + PC_W + RADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ID_W    = (N_BKPT > 1) ? $clog2(N_BKPT) : 1;

    // Control pulses
    logic                     arm;
    logic                     resume;

    // Core retire / writeback events
    logic                     pc_valid;
    logic [PC_W-1:0]          pc;
    logic                     wb_valid;
    logic [RADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     end_in;

    // Configuration
    logic [N_BKPT*PC_W-1:0]   bkpt_pc;
    logic [N_BKPT-1:0]        bkpt_en;
    logic [TMO_W-1:0]         tmo_limit;

    // Host pop port and status
    logic                     rd_en;
    logic                     rd_valid;
    logic [ENTRY_W-1:0]       rd_data;
    logic [CNT_W-1:0]         trace_count;
    logic                     overflow;
    logic                     halt_req;
    logic [ID_W-1:0]          bkpt_id;
    logic                     timeout_flag;
    logic                     done;

    modport master (
        output arm, resume, pc_valid, pc, wb_valid, wb_addr, wb_data, end_in,
               bkpt_pc, bkpt_en, tmo_limit, rd_en,
        input  rd_valid, rd_data, trace_count, overflow, halt_req, bkpt_id,
               timeout_flag, done
    );

    modport slave (
        input  arm, resume, pc_valid, pc, wb_valid, wb_addr, wb_data, end_in,
               bkpt_pc, bkpt_en, tmo_limit, rd_en,
        output rd_valid, rd_data, trace_count, overflow, halt_req, bkpt_id,
               timeout_flag, done
    );
endinterface

// File: rtl/exec_trace_monitor.sv
// Execution trace and watchdog unit for one classical_ctrl core.
// Records retire/writeback events into a circular buffer popped by the host,
// halts the core on PC breakpoints, and flags an idle-core watchdog timeout.
module exec_trace_monitor #(
    parameter int PC_W    = 11,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 16,
    parameter int N_BKPT  = 2,
    parameter int TMO_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    exec_trace_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ID_W    = (N_BKPT > 1) ? $clog2(N_BKPT) : 1;
    localparam int ENTRY_W = 2 + PC_W + RADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_TMO,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic [ID_W-1:0]    bkpt_id_q, bkpt_id_d;

    logic               bkpt_hit;
    logic [ID_W-1:0]    hit_id;

    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow_q;
    logic               rd_valid_q;
    logic [ENTRY_W-1:0] rd_data_q;

    logic               capture;
    logic               pop;
    logic               full;

    // Breakpoint comparators: the lowest enabled matching slot wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bkpt_hit = 1'b0;
        hit_id   = '0;
        for (int i = N_BKPT - 1; i >= 0; i--) begin
            if (bus.bkpt_en[i] && (bus.pc == bus.bkpt_pc[i*PC_W +: PC_W])) begin
                bkpt_hit = 1'b1;
                hit_id   = ID_W'(i);
            end
        end
        bkpt_hit = bkpt_hit & bus.pc_valid;
    end

    // Next-state logic: arm overrides everything; in RUN breakpoint > end > timeout.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        bkpt_id_d = bkpt_id_q;
        if (bus.arm) begin
            state_d   = S_RUN;
            wd_d      = '0;
            bkpt_id_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bkpt_hit) begin
                        state_d   = S_HALTED;
                        bkpt_id_d = hit_id;
                    end else if (bus.end_in) begin
                        state_d = S_DONE;
                    end else if (bus.pc_valid) begin
                        wd_d = '0;
                    end else if ((bus.tmo_limit != '0) &&
                                 (wd_q == bus.tmo_limit - TMO_W'(1))) begin
                        state_d = S_TMO;
                    end else begin
                        wd_d = wd_q + TMO_W'(1);
                    end
                end
                S_HALTED: begin
                    if (bus.resume) begin
                        state_d = S_RUN;
                        wd_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, watchdog and breakpoint-id registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            bkpt_id_q <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            bkpt_id_q <= bkpt_id_d;
        end
    end

    // Trace entry layout {pc_vld, wb_vld, pc, wb_addr, wb_data}; absent fields read as 0.
    always_comb begin
        entry              = '0;
        entry[ENTRY_W-1]   = bus.pc_valid;
        entry[ENTRY_W-2]   = bus.wb_valid;
        if (bus.pc_valid) begin
            entry[DATA_W+RADDR_W +: PC_W] = bus.pc;
        end
        if (bus.wb_valid) begin
            entry[DATA_W +: RADDR_W] = bus.wb_addr;
            entry[DATA_W-1:0]        = bus.wb_data;
        end
    end

    assign capture = (state_q == S_RUN) && !bus.arm && (bus.pc_valid || bus.wb_valid);
    assign pop     = bus.rd_en && !bus.arm && (count != '0);
    assign full    = (count == CNT_W'(DEPTH));

    // Buffer bookkeeping: pointers, occupancy, overflow and the pop port.
    // A write into a full buffer drops the oldest entry unless a pop removes it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem[rd_ptr];
            end
            if (bus.arm) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (capture) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop || (capture && full)) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (capture && !pop && !full) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !capture) begin
                    count <= count - CNT_W'(1);
                end
                if (capture && full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Trace storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; count says which entries are live, and a reset-free array can map to RAM.
        if (capture) begin
            mem[wr_ptr] <= entry;
        end
    end

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.trace_count  = count;
    assign bus.overflow     = overflow_q;
    assign bus.halt_req     = (state_q == S_HALTED);
    assign bus.bkpt_id      = bkpt_id_q;
    assign bus.timeout_flag = (state_q == S_TMO);
    assign bus.done         = (state_q == S_DONE);

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Self-checking bench for exec_trace_monitor: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based reference model.
module tb_exec_trace_monitor;
    localparam int PC_W    = 11;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int DEPTH   = 16;
    localparam int N_BKPT  = 2;
    localparam int TMO_W   = 16;
    localparam int ENTRY_W = 2 + PC_W + RADDR_W + DATA_W;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_TMO  = 3;
    localparam int M_DONE = 4;

    localparam logic [ENTRY_W-1:0] T1_E2 = {1'b1, 1'b1, 11'd2, 5'd10, 32'd10};

    logic clk = 1'b0;
    logic rst;

    exec_trace_if #(
        .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W),
        .DEPTH(DEPTH), .N_BKPT(N_BKPT), .TMO_W(TMO_W)
    ) bus ();

    exec_trace_monitor #(
        .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W),
        .DEPTH(DEPTH), .N_BKPT(N_BKPT), .TMO_W(TMO_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of entries plus an abstract mode.
    logic [ENTRY_W-1:0] m_q[$];
    int                 m_mode;
    int                 m_idle;
    int                 m_bkpt_id;
    bit                 m_ovf;
    bit                 m_rd_valid;
    bit                 m_data_known;
    logic [ENTRY_W-1:0] m_rd_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PC_W-1:0] pc_of(input logic [ENTRY_W-1:0] e);
        return e[DATA_W+RADDR_W +: PC_W];
    endfunction

    function automatic logic [ENTRY_W-1:0] make_entry();
        logic [PC_W-1:0]    p;
        logic [RADDR_W-1:0] a;
        logic [DATA_W-1:0]  d;
        p = bus.pc_valid ? bus.pc : '0;
        a = bus.wb_valid ? bus.wb_addr : '0;
        d = bus.wb_valid ? bus.wb_data : '0;
        return {bus.pc_valid, bus.wb_valid, p, a, d};
    endfunction

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_step();
        int hit;
        if (rst) begin
            m_q.delete();
            m_mode = M_IDLE; m_idle = 0; m_bkpt_id = 0; m_ovf = 0;
            m_rd_valid = 0; m_rd_data = '0; m_data_known = 1;
            return;
        end
        if (bus.arm) begin
            m_q.delete();
            m_mode = M_RUN; m_idle = 0; m_bkpt_id = 0; m_ovf = 0;
            m_rd_valid = 0; m_data_known = 0;
            return;
        end
        m_rd_valid   = 0;
        m_data_known = 0;
        if (bus.rd_en && m_q.size() > 0) begin
            m_rd_data    = m_q.pop_front();
            m_rd_valid   = 1;
            m_data_known = 1;
        end
        if (m_mode == M_RUN) begin
            if (bus.pc_valid || bus.wb_valid) begin
                if (m_q.size() == DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_q.push_back(make_entry());
            end
            hit = -1;
            for (int i = 0; i < N_BKPT; i++) begin
                if (hit < 0 && bus.pc_valid && bus.bkpt_en[i] &&
                    bus.pc == bus.bkpt_pc[i*PC_W +: PC_W]) hit = i;
            end
            if (hit >= 0) begin
                m_mode = M_HALT;
                m_bkpt_id = hit;
            end else if (bus.end_in) begin
                m_mode = M_DONE;
            end else if (bus.pc_valid) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (bus.tmo_limit != 0 && m_idle == int'(bus.tmo_limit)) m_mode = M_TMO;
            end
        end else if (m_mode == M_HALT && bus.resume) begin
            m_mode = M_RUN;
            m_idle = 0;
        end
    endtask

    task automatic check_outputs();
        check("trace_count", 64'(bus.trace_count), 64'(m_q.size()));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        check("halt_req", 64'(bus.halt_req), 64'(m_mode == M_HALT));
        check("bkpt_id", 64'(bus.bkpt_id), 64'(m_bkpt_id));
        check("timeout_flag", 64'(bus.timeout_flag), 64'(m_mode == M_TMO));
        check("done", 64'(bus.done), 64'(m_mode == M_DONE));
        check("rd_valid", 64'(bus.rd_valid), 64'(m_rd_valid));
        if (m_data_known) check("rd_data", 64'(bus.rd_data), 64'(m_rd_data));
    endtask

    // One clock: predict, clock, compare #1 after the edge, then drop pulse inputs.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        bus.arm = 0; bus.resume = 0; bus.pc_valid = 0; bus.wb_valid = 0;
        bus.end_in = 0; bus.rd_en = 0;
    endtask

    task automatic feed_pc(input int p);
        bus.pc_valid = 1;
        bus.pc = PC_W'(p);
        step();
    endtask

    task automatic do_arm();
        bus.arm = 1;
        step();
    endtask

    initial begin
        rst = 1;
        bus.arm = 0; bus.resume = 0; bus.pc_valid = 0; bus.pc = '0;
        bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.end_in = 0;
        bus.bkpt_pc = '0; bus.bkpt_en = '0; bus.tmo_limit = '0; bus.rd_en = 0;
        step();
        step();
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        check("reset_count", 64'(bus.trace_count), 64'd0);
        rst = 0;
        step();

        // T1: five retires, one with a writeback, popped back in order.
        do_arm();
        for (int p = 0; p < 5; p++) begin
            if (p == 2) begin
                bus.wb_valid = 1; bus.wb_addr = 5'd10; bus.wb_data = 32'd10;
            end
            feed_pc(p);
        end
        for (int k = 0; k < 5; k++) begin
            bus.rd_en = 1;
            step();
            if (k == 2) check("t1_entry2", 64'(bus.rd_data), 64'(T1_E2));
        end
        check("t1_count", 64'(bus.trace_count), 64'd0);
        check("t1_overflow", 64'(bus.overflow), 64'd0);

        // T2: 20 writes into a 16-deep buffer, no reads.
        do_arm();
        for (int p = 0; p < 20; p++) feed_pc(p);
        check("t2_count", 64'(bus.trace_count), 64'd16);
        check("t2_overflow", 64'(bus.overflow), 64'd1);
        for (int k = 0; k < 16; k++) begin
            bus.rd_en = 1;
            step();
            if (k == 0)  check("t2_first_pc", 64'(pc_of(bus.rd_data)), 64'd4);
            if (k == 15) check("t2_last_pc", 64'(pc_of(bus.rd_data)), 64'd19);
        end

        // T3: breakpoint on slot 1 only (slot 0 holds the same PC but is disabled).
        do_arm();
        bus.bkpt_pc = {11'd9, 11'd9};
        bus.bkpt_en = 2'b10;
        feed_pc(8);
        check("t3_no_halt_yet", 64'(bus.halt_req), 64'd0);
        feed_pc(9);
        check("t3_halt", 64'(bus.halt_req), 64'd1);
        check("t3_bkpt_id", 64'(bus.bkpt_id), 64'd1);
        feed_pc(10);
        check("t3_pc10_dropped", 64'(bus.trace_count), 64'd2);
        bus.resume = 1;
        step();
        check("t3_resume", 64'(bus.halt_req), 64'd0);
        bus.bkpt_en = '0;

        // T4: watchdog fires after exactly tmo_limit idle cycles; 0 disables it.
        do_arm();
        bus.tmo_limit = 16'd5;
        feed_pc(1);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) check("t4_before", 64'(bus.timeout_flag), 64'd0);
            if (i == 5) check("t4_fire", 64'(bus.timeout_flag), 64'd1);
        end
        bus.tmo_limit = 16'd0;
        do_arm();
        repeat (1000) step();
        check("t4_disabled", 64'(bus.timeout_flag), 64'd0);

        // T5: breakpoint and end in the same cycle; breakpoint wins.
        do_arm();
        bus.bkpt_pc = {11'd0, 11'd7};
        bus.bkpt_en = 2'b01;
        bus.end_in = 1;
        feed_pc(7);
        check("t5_halt", 64'(bus.halt_req), 64'd1);
        check("t5_done_low", 64'(bus.done), 64'd0);
        bus.resume = 1;
        step();
        bus.end_in = 1;
        step();
        check("t5_done", 64'(bus.done), 64'd1);
        bus.bkpt_en = '0;

        // T6: write+pop on a full buffer, then reset mid-RUN.
        do_arm();
        for (int p = 0; p < 16; p++) feed_pc(100 + p);
        bus.rd_en = 1;
        feed_pc(200);
        check("t6_oldest", 64'(pc_of(bus.rd_data)), 64'd100);
        check("t6_count", 64'(bus.trace_count), 64'd16);
        check("t6_overflow", 64'(bus.overflow), 64'd0);
        feed_pc(201);
        rst = 1;
        bus.pc_valid = 1;
        step();
        check("t6_rst_count", 64'(bus.trace_count), 64'd0);
        check("t6_rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("t6_rst_overflow", 64'(bus.overflow), 64'd0);
        rst = 0;
        step();

        // Random traffic against the model.
        do_arm();
        repeat (3000) begin
            if ($urandom_range(0, 149) == 0) begin
                bus.tmo_limit = TMO_W'($urandom_range(0, 12));
                for (int i = 0; i < N_BKPT; i++)
                    bus.bkpt_pc[i*PC_W +: PC_W] = PC_W'($urandom_range(0, 15));
                bus.bkpt_en = N_BKPT'($urandom());
            end
            bus.pc_valid = ($urandom_range(0, 1) == 1);
            bus.pc       = PC_W'($urandom_range(0, 15));
            bus.wb_valid = ($urandom_range(0, 2) == 0);
            bus.wb_addr  = RADDR_W'($urandom());
            bus.wb_data  = $urandom();
            bus.rd_en    = ($urandom_range(0, 4) < 2);
            bus.resume   = ($urandom_range(0, 3) == 0);
            bus.end_in   = ($urandom_range(0, 79) == 0);
            bus.arm      = ($urandom_range(0, 59) == 0);
            rst          = ($urandom_range(0, 699) == 0);
            step();
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
